// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded fields and operands from ID. Inserts a bubble on a
// load-use hazard, on a branch flush and once HLT has been captured. Holds
// all state while EX is back-pressured, and counts load-use bubbles in a
// saturating counter.
module id_ex_stage #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic [3:0]       id_rd,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [DW-1:0]    id_pc2,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ex_hold,
  output logic [3:0]       ex_opcode,
  output logic [3:0]       ex_rs,
  output logic [3:0]       ex_rt,
  output logic [3:0]       ex_rd,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_pc2,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             stall_if_id,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Opcode reads Rs as a source operand.
  function automatic logic uses_rs(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101: return 1'b1;
      default:                                     return (op[3] == 1'b0);
    endcase
  endfunction

  // Opcode reads Rt as a source operand.
  function automatic logic uses_rt(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Opcode writes the register file.
  function automatic logic reg_write(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1010, 4'b1011, 4'b1110: return 1'b1;
      default:                            return (op[3] == 1'b0);
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic rs_hit;
  logic rt_hit;
  logic luh;
  logic capture;
  logic count_stall;

  // Hazard detection against the load currently in EX, plus edge decisions.
  always_comb begin
    rs_hit = uses_rs(id_opcode) && (id_rs == ex_rd);
    // Store data is forwarded MEM-to-MEM, so an Rt-only match on SW is safe.
    rt_hit = uses_rt(id_opcode) && (id_rt == ex_rd) && (id_opcode != OP_SW);
    luh    = ex_valid && (ex_opcode == OP_LW) && (ex_rd != 4'd0) && id_valid
             && (rs_hit || rt_hit);
    // A squashed or post-HLT instruction never waits on a load.
    count_stall = luh && !flush && !halted;
    capture     = id_valid && !halted && !flush && !luh;
    stall_if_id = ex_hold || count_stall;
  end

  // ---- ID -> EX register: hold, bubble or capture; HLT and stall tracking ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_opcode    <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_pc2       <= '0;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      halted       <= 1'b0;
      stall_cnt    <= '0;
    end else if (!ex_hold) begin
      if (capture) begin
        ex_opcode    <= id_opcode;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_rd        <= id_rd;
        ex_rs_data   <= id_rs_data;
        ex_rt_data   <= id_rt_data;
        ex_imm       <= id_imm;
        ex_pc2       <= id_pc2;
        ex_valid     <= 1'b1;
        ex_reg_write <= reg_write(id_opcode);
        if (id_opcode == OP_HLT) halted <= 1'b1;
      end else begin
        ex_opcode    <= '0;
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_rd        <= '0;
        ex_rs_data   <= '0;
        ex_rt_data   <= '0;
        ex_imm       <= '0;
        ex_pc2       <= '0;
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
      end
      if (count_stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all compared against a set-based behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc2;
  logic        id_valid, flush, ex_hold;

  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc2;
  logic        ex_valid, ex_reg_write, stall_if_id, halted;
  logic [15:0] stall_cnt;

  // Narrow-counter instance so counter saturation is reachable quickly.
  logic [3:0]  s_opcode, s_rs, s_rt, s_rd;
  logic [15:0] s_rs_data, s_rt_data, s_imm, s_pc2;
  logic        s_valid, s_reg_write, s_stall, s_halted;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Opcode membership sets (bit n set = opcode n belongs to the set).
  logic [15:0] set_uses_rs  = 16'h2FFF;
  logic [15:0] set_uses_rt  = 16'h028F;
  logic [15:0] set_reg_wr   = 16'h4DFF;

  // Reference model state.
  logic [3:0]  m_op, m_rs, m_rt, m_rd;
  logic [15:0] m_rsd, m_rtd, m_imm, m_pc2;
  logic        m_valid, m_rw, m_halt;
  int          m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc2(id_pc2),
    .id_valid(id_valid), .flush(flush), .ex_hold(ex_hold),
    .ex_opcode(ex_opcode), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc2(ex_pc2),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .stall_if_id(stall_if_id),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DW(16), .CNT_W(3)) sat_dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc2(id_pc2),
    .id_valid(id_valid), .flush(flush), .ex_hold(ex_hold),
    .ex_opcode(s_opcode), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_pc2(s_pc2),
    .ex_valid(s_valid), .ex_reg_write(s_reg_write), .stall_if_id(s_stall),
    .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [99:0] got_vec();
    return {ex_opcode, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc2,
            ex_valid, ex_reg_write, stall_if_id, halted, stall_cnt};
  endfunction

  function automatic bit model_luh();
    bit rs_dep, rt_dep;
    if (!(m_valid && m_op == 4'd8 && m_rd != 4'd0 && id_valid)) return 1'b0;
    rs_dep = set_uses_rs[id_opcode] && (id_rs == m_rd);
    rt_dep = set_uses_rt[id_opcode] && (id_rt == m_rd) && (id_opcode != 4'd9);
    return rs_dep || rt_dep;
  endfunction

  function automatic logic [99:0] exp_vec();
    logic st;
    logic [15:0] c;
    st = ex_hold || (model_luh() && !flush && !m_halt);
    c  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    return {m_op, m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_pc2, m_valid, m_rw, st, m_halt, c};
  endfunction

  function automatic logic [2:0] exp_small_cnt();
    return (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
  endfunction

  task automatic model_reset();
    {m_op, m_rs, m_rt, m_rd} = '0;
    {m_rsd, m_rtd, m_imm, m_pc2} = '0;
    m_valid = 0; m_rw = 0; m_halt = 0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    {m_op, m_rs, m_rt, m_rd} = '0;
    {m_rsd, m_rtd, m_imm, m_pc2} = '0;
    m_valid = 0; m_rw = 0;
  endtask

  // Advance one clock edge and apply the specified per-edge priority to the model.
  task automatic tick();
    bit l;
    l = model_luh();
    @(posedge clk);
    if (!ex_hold) begin
      if (m_halt || flush || !id_valid || l) begin
        if (l && !m_halt && !flush) m_cnt++;
        model_bubble();
      end else begin
        m_op = id_opcode; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_pc2 = id_pc2;
        m_valid = 1'b1; m_rw = set_reg_wr[id_opcode];
        if (id_opcode == 4'hF) m_halt = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic v);
    id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; id_valid = v;
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
    id_imm = 16'($urandom); id_pc2 = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; ex_hold = 0;
    set_id(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 100'd0) begin
      errors++; $display("FAIL reset_now: got %h want 0", got_vec());
    end
    set_id(4'd2, 4'd1, 4'd2, 4'd3, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (got_vec() !== 100'd0 || s_stall_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_held: got %h want 0", got_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 1'b1);      // LW R3
    tick();
    checks++;
    if (ex_opcode !== 4'd8 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL lu_load_captured: got %h want %h", got_vec(), exp_vec());
    end
    set_id(4'd0, 4'd3, 4'd5, 4'd4, 1'b1);      // ADD R4,R3,R5
    #1;
    checks++;
    if (stall_if_id !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %b want 1", stall_if_id);
    end
    tick();
    checks++;
    if (ex_opcode !== 4'd0 || ex_valid !== 1'b0 || stall_cnt !== 16'd1 || stall_if_id !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got op=%h v=%b cnt=%0d st=%b want op=0 v=0 cnt=1 st=0",
                         ex_opcode, ex_valid, stall_cnt, stall_if_id);
    end
    tick();
    checks++;
    if (ex_opcode !== 4'd0 || ex_rs !== 4'd3 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1
        || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL lu_release: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_store_exception();
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 1'b1);      // LW R3
    tick();
    set_id(4'd9, 4'd2, 4'd3, 4'd0, 1'b1);      // SW rt=3 rs=2
    #1;
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL sw_rt_no_stall: got %b want 0", stall_if_id);
    end
    tick();
    checks++;
    if (ex_opcode !== 4'd9 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL sw_captured: got op=%h v=%b rw=%b want op=9 v=1 rw=0",
                         ex_opcode, ex_valid, ex_reg_write);
    end
    set_id(4'd8, 4'd1, 4'd0, 4'd0, 1'b1);      // LW R0
    tick();
    set_id(4'd0, 4'd0, 4'd0, 4'd5, 1'b1);      // ADD using R0
    #1;
    checks++;
    if (stall_if_id !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL r0_no_stall: got %h want %h", got_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 1'b1);
    tick();
    c0 = stall_cnt;
    set_id(4'd1, 4'd3, 4'd6, 4'd7, 1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b want 0", stall_if_id);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== 4'd0 || stall_cnt !== c0) begin
      errors++; $display("FAIL flush_bubble: got v=%b op=%h cnt=%0d want v=0 op=0 cnt=%0d",
                         ex_valid, ex_opcode, stall_cnt, c0);
    end
  endtask

  task automatic test_hold();
    logic [99:0] saved;
    set_id(4'd3, 4'd4, 4'd5, 4'd6, 1'b1);
    tick();
    ex_hold = 1'b1;
    set_id(4'd2, 4'd7, 4'd8, 4'd9, 1'b1);
    #1;
    saved = got_vec();
    for (int i = 0; i < 3; i++) begin
      tick();
      set_id(4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      #1;
      checks++;
      if (got_vec() !== saved || stall_if_id !== 1'b1) begin
        errors++; $display("FAIL hold_%0d: got %h want %h", i, got_vec(), saved);
      end
    end
    ex_hold = 1'b0;
    set_id(4'd2, 4'd10, 4'd11, 4'd12, 1'b1);
    tick();
    checks++;
    if (ex_opcode !== 4'd2 || ex_rd !== 4'd12 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL hold_release: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_halt();
    set_id(4'hF, 4'd0, 4'd0, 4'd0, 1'b1);
    tick();
    checks++;
    if (halted !== 1'b1 || ex_opcode !== 4'hF || ex_valid !== 1'b1) begin
      errors++; $display("FAIL halt_capture: got h=%b op=%h v=%b want h=1 op=f v=1",
                         halted, ex_opcode, ex_valid);
    end
    for (int i = 0; i < 3; i++) begin
      set_id(4'd0, 4'd1, 4'd2, 4'd3, 1'b1);
      tick();
      checks++;
      if (ex_valid !== 1'b0 || halted !== 1'b1 || got_vec() !== exp_vec()) begin
        errors++; $display("FAIL halt_bubble_%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (halted !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL halt_reset: got %h want %h", got_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    set_id(4'd8, 4'd3, 4'd0, 4'd3, 1'b1);      // LW R3,(R3): stalls on itself
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec() || s_stall_cnt !== exp_small_cnt()) begin
        errors++; $display("FAIL sat_step_%0d: got %h/%0d want %h/%0d", i, got_vec(),
                           s_stall_cnt, exp_vec(), exp_small_cnt());
      end
    end
    checks++;
    if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'd10) begin
      errors++; $display("FAIL sat_final: got small=%0d wide=%0d want small=7 wide=10",
                         s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 1'b1);
    tick();
    set_id(4'd0, 4'd3, 4'd5, 4'd4, 1'b1);
    #1;
    checks++;
    if (stall_if_id !== 1'b1 || ex_opcode !== 4'd8) begin
      errors++; $display("FAIL areset_setup: got st=%b op=%h want st=1 op=8", stall_if_id, ex_opcode);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 100'd0 || s_stall_cnt !== 3'd0) begin
      errors++; $display("FAIL areset_clear: got %h want 0", got_vec());
    end
    ex_hold = 1'b1;
    #1;
    checks++;
    if (stall_if_id !== 1'b1 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL areset_hold: got st=%b v=%b want st=1 v=0", stall_if_id, ex_valid);
    end
    ex_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 14)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (got_vec() !== exp_vec() || s_stall_cnt !== exp_small_cnt()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, got_vec(), exp_vec());
      end
      tick();
    end
    flush = 1'b0; ex_hold = 1'b0;
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL random_end: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_store_exception();
    test_flush();
    test_hold();
    test_halt();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
